// File: rtl/xlib_avalon_dma_rd.sv
// rtl/xlib_avalon_dma_rd.sv - single-channel read DMA master feeding an Avalon burst-read slave
// Splits a descriptor into credit-limited bursts and streams returned beats out of a local FIFO.
`timescale 1ns/1ps
module xlib_avalon_dma_rd #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int BL   = 4,
    parameter int BI   = 1,
    parameter int MAXB = 16,
    parameter int LW   = 16,
    parameter int FD   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_val,
    output logic          cmd_rdy,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          busy,
    output logic          done,
    output logic          rval,
    input  logic          rrdy,
    output logic [BL-1:0] rlen,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    input  logic          rdval,
    output logic [DW-1:0] odata,
    output logic          oval,
    input  logic          ordy
);
    localparam int BS = DW / 8;
    localparam int AL = $clog2(BS);
    localparam int NW = $clog2(MAXB + 1);
    localparam int PW = $clog2(FD);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] pend_q, pend_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          rval_q, rval_d;
    logic [BL-1:0] rlen_q, rlen_d;
    logic [AW-1:0] raddr_q, raddr_d;

    logic [DW-1:0] mem_q [FD];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          push, pop, accept;
    logic [NW-1:0] n_cur, n_nx;
    logic [CW-1:0] credit_nx;

    function automatic logic [NW-1:0] burst_beats(input logic [LW-1:0] r);
        if (r >= LW'(MAXB)) begin
            return NW'(MAXB);
        end
        return NW'(r);
    endfunction

    assign cmd_rdy = (state_q == IDLE) && !rst;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rval    = rval_q;
    assign rlen    = rlen_q;
    assign raddr   = raddr_q;
    assign oval    = (fifo_cnt_q != '0);
    assign odata   = mem_q[rd_ptr_q];

    always_comb begin
        push       = rdval;
        pop        = oval && ordy;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        pend_d  = pend_q - LW'(pop);
        outst_d = outst_q - CW'(rdval);
        accept  = rval_q && rrdy;
        n_cur   = burst_beats(rem_q);
        case (state_q)
            IDLE: begin
                if (cmd_val) begin
                    addr_d  = cmd_addr & ~(AW'(BS - 1));
                    rem_d   = cmd_len;
                    pend_d  = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d  = addr_q + (AW'(n_cur) << AL);
                    rem_d   = rem_q - LW'(n_cur);
                    outst_d = outst_q + CW'(n_cur) - CW'(rdval);
                    if (rem_d == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pend_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Credit is judged on next-cycle occupancy so a raised request is always safe;
        // while it waits for rrdy, fifo_cnt + outstanding can only shrink.
        n_nx      = burst_beats(rem_d);
        credit_nx = CW'(FD) - fifo_cnt_d - outst_d;
        rval_d    = rval_q && !rrdy;
        rlen_d    = rlen_q;
        raddr_d   = raddr_q;
        if ((!rval_q || rrdy) && (state_d == ISSUE) && (credit_nx >= CW'(n_nx))) begin
            rval_d  = 1'b1;
            rlen_d  = BL'(n_nx - NW'(1) + NW'(BI));
            raddr_d = addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            pend_q     <= '0;
            outst_q    <= '0;
            rval_q     <= 1'b0;
            rlen_q     <= '0;
            raddr_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            pend_q     <= pend_d;
            outst_q    <= outst_d;
            rval_q     <= rval_d;
            rlen_q     <= rlen_d;
            raddr_q    <= raddr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rdata;
        end
    end

    // Returned data with nothing outstanding means the slave is out of step with us.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rdval && (outst_q == '0)));
        end
    end
endmodule

// File: tb/tb_xlib_avalon_dma_rd.sv
// tb/tb_xlib_avalon_dma_rd.sv - directed bench for xlib_avalon_dma_rd with a queued burst-read slave model
`timescale 1ns/1ps
module tb_xlib_avalon_dma_rd;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_val, cmd_rdy;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy, done, rval, rrdy, rdval, oval, ordy;
    logic [3:0]  rlen;
    logic [31:0] raddr, rdata, odata;

    always #5 clk = ~clk;

    xlib_avalon_dma_rd dut (
        .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
        .rval(rval), .rrdy(rrdy), .rlen(rlen), .raddr(raddr),
        .rdata(rdata), .rdval(rdval), .odata(odata), .oval(oval), .ordy(ordy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          rrdy_pct;
        int          ordy_pct;
        int          rd_pct;
        int          nb;
        logic [31:0] first_raddr;
        logic [31:0] last_raddr;
        logic [3:0]  last_rlen;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int rrdy_pct = 100, ordy_pct = 100, rd_pct = 100;
    int done_cnt = 0, beats_out = 0, occ = 0, max_occ = 0;
    logic [31:0] beat_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] braddr_q[$];
    logic [3:0]  brlen_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Slave model and output monitor: everything decided at negedge applies at the next posedge.
    initial begin : slave_monitor
        logic [3:0] t;
        rrdy = 1'b0; rdval = 1'b0; rdata = '0; ordy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_q.delete();
                rdval = 1'b0; rrdy = 1'b0; ordy = 1'b0; occ = 0;
            end else begin
                rrdy = ($urandom_range(99) < rrdy_pct);
                ordy = ($urandom_range(99) < ordy_pct);
                if (beat_q.size() > 0 && $urandom_range(99) < rd_pct) begin
                    rdval = 1'b1;
                    rdata = mem_fn(beat_q.pop_front());
                end else begin
                    rdval = 1'b0;
                end
                if (done) done_cnt++;
                if (rval && rrdy) begin
                    braddr_q.push_back(raddr);
                    brlen_q.push_back(rlen);
                    t = rlen - 4'd1;
                    for (int i = 0; i < int'(t) + 1; i++) beat_q.push_back(raddr + 32'(i * 4));
                end
                if (oval && ordy) begin
                    beats_out++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_beat actual=0x%0h required=none", odata);
                    end else begin
                        check("beat_data", odata, mem_fn(exp_q.pop_front()));
                    end
                end
                occ = occ + int'(rdval) - int'(oval && ordy);
                if (occ > max_occ) max_occ = occ;
            end
        end
    end

    task automatic start_desc(input logic [31:0] a, input logic [15:0] len);
        logic [31:0] base;
        int w;
        base = a & ~32'h3;
        exp_q.delete(); braddr_q.delete(); brlen_q.delete();
        done_cnt = 0; beats_out = 0; max_occ = 0;
        for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 32'(i) * 32'd4);
        @(negedge clk);
        cmd_addr = a; cmd_len = len; cmd_val = 1'b1;
        w = 0;
        while (!cmd_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("cmd_accept", 32'(cmd_rdy), 32'd1);
        @(posedge clk); #1;
        cmd_val = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int w;
        w = 0;
        while (done_cnt == 0 && w < limit) begin
            @(posedge clk);
            w++;
        end
        check("done_seen_in_time", 32'(done_cnt != 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin : main
        int w;
        rst = 1'b1; cmd_val = 1'b0; cmd_addr = '0; cmd_len = '0;
        vt[0] = '{32'h0000_0100, 16'd40,   100, 100, 100,  3, 32'h0000_0100, 32'h0000_0180, 4'd8};
        vt[1] = '{32'h0000_0103, 16'd5,    100, 100, 100,  1, 32'h0000_0100, 32'h0000_0100, 4'd5};
        vt[2] = '{32'h0000_2000, 16'd16,   100, 100, 100,  1, 32'h0000_2000, 32'h0000_2000, 4'd0};
        vt[3] = '{32'h0000_0010, 16'd17,    50,  70,  60,  2, 32'h0000_0010, 32'h0000_0050, 4'd1};
        vt[4] = '{32'hFFFF_FFF0, 16'd20,   100, 100, 100,  2, 32'hFFFF_FFF0, 32'h0000_0030, 4'd4};
        vt[5] = '{32'h0000_4000, 16'd1000,  50,  30,  40, 63, 32'h0000_4000, 32'h0000_4F80, 4'd8};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_rval",    32'(rval),    32'd0);
        check("rst_oval",    32'(oval),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);

        for (int i = 0; i < 6; i++) begin
            rrdy_pct = vt[i].rrdy_pct; ordy_pct = vt[i].ordy_pct; rd_pct = vt[i].rd_pct;
            start_desc(vt[i].addr, vt[i].len);
            wait_done(20000);
            check($sformatf("v%0d_done_count", i), 32'(done_cnt), 32'd1);
            check($sformatf("v%0d_beats_out", i), 32'(beats_out), 32'(vt[i].len));
            check($sformatf("v%0d_burst_count", i), 32'(braddr_q.size()), 32'(vt[i].nb));
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_max_occ_le_fd", i), 32'(max_occ <= 32), 32'd1);
            if (braddr_q.size() > 0) begin
                check($sformatf("v%0d_first_raddr", i), braddr_q[0], vt[i].first_raddr);
                check($sformatf("v%0d_last_raddr", i), braddr_q[braddr_q.size()-1], vt[i].last_raddr);
                check($sformatf("v%0d_last_rlen", i), 32'(brlen_q[brlen_q.size()-1]), 32'(vt[i].last_rlen));
            end
        end

        // Zero-length descriptor: straight to DONE, no requests.
        rrdy_pct = 100; ordy_pct = 100; rd_pct = 100;
        start_desc(32'h0000_0500, 16'd0);
        check("len0_done_high", 32'(done), 32'd1);
        check("len0_busy_high", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("len0_done_low", 32'(done), 32'd0);
        check("len0_cmd_rdy", 32'(cmd_rdy), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("len0_no_bursts", 32'(braddr_q.size()), 32'd0);
        check("len0_done_count", 32'(done_cnt), 32'd1);

        // Output stalled: requests must stop once the FIFO is fully committed.
        ordy_pct = 0;
        start_desc(32'h0000_0800, 16'd64);
        repeat (200) @(posedge clk);
        #1;
        check("bp_bursts_stalled", 32'(braddr_q.size()), 32'd2);
        check("bp_rval_low", 32'(rval), 32'd0);
        check("bp_oval_full", 32'(oval), 32'd1);
        check("bp_beats_out", 32'(beats_out), 32'd0);
        check("bp_max_occ", 32'(max_occ), 32'd32);
        ordy_pct = 100;
        wait_done(2000);
        check("bp_bursts_total", 32'(braddr_q.size()), 32'd4);
        check("bp_beats_total", 32'(beats_out), 32'd64);
        check("bp_done_count", 32'(done_cnt), 32'd1);
        check("bp_max_occ_end", 32'(max_occ <= 32), 32'd1);

        // Reset in the middle of a descriptor, then a clean descriptor afterwards.
        start_desc(32'h0000_1000, 16'd100);
        w = 0;
        while (beats_out < 5 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("mid_rst_progress", 32'(beats_out >= 5), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rval", 32'(rval), 32'd0);
        check("mid_rst_oval", 32'(oval), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start_desc(32'h0000_0300, 16'd20);
        wait_done(2000);
        check("post_rst_done_count", 32'(done_cnt), 32'd1);
        check("post_rst_beats", 32'(beats_out), 32'd20);
        check("post_rst_bursts", 32'(braddr_q.size()), 32'd2);
        if (braddr_q.size() == 2) begin
            check("post_rst_raddr1", braddr_q[1], 32'h0000_0340);
            check("post_rst_rlen1", 32'(brlen_q[1]), 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
